// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multi-digit time-multiplexed 7-segment driver.
// Double-buffered BCD word, active-low anode scan, blanking and hex mode.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 1000,
  parameter bit HEX      = 1'b0,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     dpb_q, dpb_d;
  logic [4*DIGITS-1:0]   pbcd_q, pbcd_d;
  logic [DIGITS-1:0]     pdp_q, pdp_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  wrap;
  logic                  nz;
  logic                  lz;
  logic                  dot;
  logic [3:0]            cur;

  function automatic logic [6:0] dec(input logic [3:0] c);
    logic [6:0] s;
    unique case (c)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = HEX ? 7'b0001000 : 7'b1111111;
      4'hB: s = HEX ? 7'b1100000 : 7'b1111111;
      4'hC: s = HEX ? 7'b0110001 : 7'b1111111;
      4'hD: s = HEX ? 7'b1000010 : 7'b1111111;
      4'hE: s = HEX ? 7'b0110000 : 7'b1111111;
      4'hF: s = HEX ? 7'b0111000 : 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan counters, frame buffering and next registered display outputs.
  always_comb begin
    wrap    = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    if (cnt_q == CNT_LAST)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    disp_d  = disp_q;
    dpb_d   = dpb_q;
    pbcd_d  = pbcd_q;
    pdp_d   = pdp_q;
    pend_d  = pend_q;
    if (wrap) begin
      // A load coinciding with the wrap bypasses the pending buffer.
      if (load) begin
        disp_d = bcd;
        dpb_d  = dp_in;
      end else if (pend_q) begin
        disp_d = pbcd_q;
        dpb_d  = pdp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pbcd_d = bcd;
      pdp_d  = dp_in;
      pend_d = 1'b1;
    end

    // Walk from the top digit so nz tracks "any nonzero at or above i".
    nz  = 1'b0;
    lz  = 1'b0;
    dot = 1'b0;
    cur = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (disp_q[4*i +: 4] != 4'd0);
      if (idx_q == IW'(i)) begin
        cur = disp_q[4*i +: 4];
        dot = dpb_q[i];
        lz  = BLANK_LZ && (i > 0) && !nz;
      end
    end

    seg_d   = (blank || lz) ? 7'b1111111 : dec(cur);
    dp_d    = blank ? 1'b1 : ~dot;
    an_d    = blank ? '1 : ~(DIGITS'(1) << idx_q);
    frame_d = wrap;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      dpb_q   <= '0;
      pbcd_q  <= '0;
      pdp_q   <= '0;
      pend_q  <= 1'b0;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dpb_q   <= dpb_d;
      pbcd_q  <= pbcd_d;
      pdp_q   <= pdp_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign pending = pend_q;
  assign frame   = frame_q;

endmodule
